// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free preg numbers with
// per-ROB-tag read-pointer checkpoints for single-cycle mispredict recovery.
module free_list #(
   parameter int unsigned NUM_PREGS = 128,
   parameter int unsigned ARCH_REGS = 32,
   parameter int unsigned ROB_DEPTH = 16,
   localparam int unsigned PREG_W   = $clog2(NUM_PREGS),
   localparam int unsigned ROB_W    = $clog2(ROB_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              recover_i,
   input  logic [ROB_W-1:0]  recover_tag_i,
   input  logic              checkpoint_take_i,
   input  logic [ROB_W-1:0]  checkpoint_tag_i,
   input  logic              alloc_valid_i,
   output logic              alloc_ready_o,
   output logic [PREG_W-1:0] alloc_preg_o,
   input  logic              free_req_i,
   input  logic [PREG_W-1:0] free_preg_i,
   output logic [PREG_W:0]   free_count_o,
   output logic              overflow_o
);

   localparam int unsigned PTR_W     = PREG_W + 1;
   localparam int unsigned FREE_INIT = NUM_PREGS - ARCH_REGS;

   typedef logic [PREG_W-1:0] mem_t  [NUM_PREGS];
   typedef logic [PTR_W-1:0]  ckpt_t [ROB_DEPTH];

   // Power-on contents: pregs ARCH_REGS..NUM_PREGS-1 are free.
   function automatic mem_t init_mem();
      mem_t m;
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
         m[i] = (i < FREE_INIT) ? PREG_W'(ARCH_REGS + i) : '0;
      end
      return m;
   endfunction

   mem_t                 mem_q, mem_d;
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   ckpt_t                ckpt_head_q, ckpt_head_d;
   logic [ROB_DEPTH-1:0] ckpt_valid_q, ckpt_valid_d;
   logic                 overflow_q, overflow_d;

   logic [PTR_W-1:0] count;
   logic             flush_only;
   logic             alloc_fire;
   logic             free_valid;
   logic             free_drop;
   logic             free_fire;

   // Outputs and fire conditions, derived from registered state.
   always_comb begin
      count         = tail_q - head_q;
      alloc_ready_o = (count != '0);
      alloc_preg_o  = mem_q[head_q[PREG_W-1:0]];
      free_count_o  = count;
      overflow_o    = overflow_q;
      flush_only    = flush_i & ~recover_i;
      alloc_fire    = alloc_valid_i & alloc_ready_o & ~recover_i & ~flush_i;
      free_valid    = free_req_i & (free_preg_i != '0) & ~flush_only;
      // A free into a full list is only legal if an alloc makes room this cycle.
      free_drop     = free_valid & (count == PTR_W'(FREE_INIT)) & ~alloc_fire;
      free_fire     = free_valid & ~free_drop;
   end

   // Next-state: flush reinit, else alloc/free then recover or checkpoint.
   always_comb begin
      mem_d        = mem_q;
      head_d       = head_q;
      tail_d       = tail_q;
      ckpt_head_d  = ckpt_head_q;
      ckpt_valid_d = ckpt_valid_q;
      overflow_d   = overflow_q;
      if (flush_only) begin
         mem_d        = init_mem();
         head_d       = '0;
         tail_d       = PTR_W'(FREE_INIT);
         ckpt_valid_d = '0;
         overflow_d   = 1'b0;
      end else begin
         if (alloc_fire) begin
            head_d = head_q + PTR_W'(1);
         end
         if (free_fire) begin
            mem_d[tail_q[PREG_W-1:0]] = free_preg_i;
            tail_d                    = tail_q + PTR_W'(1);
         end
         if (free_drop) begin
            overflow_d = 1'b1;
         end
         if (recover_i) begin
            // Tail is kept: commits continue while the speculative head rewinds.
            if (ckpt_valid_q[recover_tag_i]) begin
               head_d = ckpt_head_q[recover_tag_i];
            end
            ckpt_valid_d = '0;
         end else if (checkpoint_take_i) begin
            ckpt_head_d[checkpoint_tag_i]  = head_q + PTR_W'(alloc_fire);
            ckpt_valid_d[checkpoint_tag_i] = 1'b1;
         end
      end
   end

   // State registers with asynchronous reset to power-on contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q        <= init_mem();
         head_q       <= '0;
         tail_q       <= PTR_W'(FREE_INIT);
         ckpt_head_q  <= '{default: '0};
         ckpt_valid_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         ckpt_head_q  <= ckpt_head_d;
         ckpt_valid_q <= ckpt_valid_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: hand-written vector table plus a scoreboard fed by a
// position-indexed model of the free list.
module tb_free_list;

   localparam int NP = 128;
   localparam int AR = 32;
   localparam int RD = 16;
   localparam int FI = NP - AR;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush_i = 1'b0;
   logic       recover_i = 1'b0;
   logic [3:0] recover_tag_i = '0;
   logic       checkpoint_take_i = 1'b0;
   logic [3:0] checkpoint_tag_i = '0;
   logic       alloc_valid_i = 1'b0;
   logic       alloc_ready_o;
   logic [6:0] alloc_preg_o;
   logic       free_req_i = 1'b0;
   logic [6:0] free_preg_i = '0;
   logic [7:0] free_count_o;
   logic       overflow_o;

   free_list #(.NUM_PREGS(NP), .ARCH_REGS(AR), .ROB_DEPTH(RD)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush_i          (flush_i),
      .recover_i        (recover_i),
      .recover_tag_i    (recover_tag_i),
      .checkpoint_take_i(checkpoint_take_i),
      .checkpoint_tag_i (checkpoint_tag_i),
      .alloc_valid_i    (alloc_valid_i),
      .alloc_ready_o    (alloc_ready_o),
      .alloc_preg_o     (alloc_preg_o),
      .free_req_i       (free_req_i),
      .free_preg_i      (free_preg_i),
      .free_count_o     (free_count_o),
      .overflow_o       (overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit alloc; bit free; int fpreg;
      bit ck; int ctag; bit rec; int rtag; bit flush;
   } stim_t;

   typedef struct {
      stim_t s; bit er; int ep; int ec; bit eo;
   } vec_t;

   typedef struct {
      bit ready; int preg; int count; bit ovf;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];

   // Model: entries held at absolute (never wrapping) positions.
   int m_mem[int];
   int m_head, m_tail;
   bit m_ovf;
   bit m_cv[RD];
   int m_ch[RD];

   function automatic stim_t S(bit a, bit f, int fp, bit ck, int ct, bit rc, int rt, bit fl);
      stim_t s;
      s.alloc = a; s.free = f; s.fpreg = fp; s.ck = ck; s.ctag = ct;
      s.rec = rc; s.rtag = rt; s.flush = fl;
      return s;
   endfunction

   function automatic vec_t V(stim_t s, bit er, int ep, int ec, bit eo);
      vec_t v;
      v.s = s; v.er = er; v.ep = ep; v.ec = ec; v.eo = eo;
      return v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_init();
      m_mem.delete();
      for (int i = 0; i < FI; i++) m_mem[i] = AR + i;
      m_head = 0;
      m_tail = FI;
      m_ovf  = 1'b0;
      for (int i = 0; i < RD; i++) m_cv[i] = 1'b0;
   endtask

   function automatic exp_t m_out();
      exp_t e;
      e.count = m_tail - m_head;
      e.ready = (e.count != 0);
      e.preg  = e.ready ? m_mem[m_head] : 0;
      e.ovf   = m_ovf;
      return e;
   endfunction

   // Oldest position still reachable by a live checkpoint or the head.
   function automatic int m_span();
      int lo = m_head;
      for (int i = 0; i < RD; i++) if (m_cv[i] && m_ch[i] < lo) lo = m_ch[i];
      return m_tail - lo;
   endfunction

   task automatic m_step(stim_t s);
      bit fl_only, af, fv, drop;
      int nh;
      fl_only = s.flush && !s.rec;
      af      = s.alloc && (m_tail != m_head) && !s.rec && !s.flush;
      fv      = s.free && (s.fpreg != 0) && !fl_only;
      drop    = fv && (m_tail - m_head == FI) && !af;
      if (fl_only) begin
         m_init();
      end else begin
         nh = m_head + int'(af);
         if (fv && !drop) begin
            m_mem[m_tail] = s.fpreg;
            m_tail++;
         end
         if (drop) m_ovf = 1'b1;
         if (s.rec) begin
            if (m_cv[s.rtag]) nh = m_ch[s.rtag];
            for (int i = 0; i < RD; i++) m_cv[i] = 1'b0;
         end else if (s.ck) begin
            m_ch[s.ctag] = nh;
            m_cv[s.ctag] = 1'b1;
         end
         m_head = nh;
      end
   endtask

   task automatic drive(stim_t s);
      alloc_valid_i     = s.alloc;
      free_req_i        = s.free;
      free_preg_i       = 7'(s.fpreg);
      checkpoint_take_i = s.ck;
      checkpoint_tag_i  = 4'(s.ctag);
      recover_i         = s.rec;
      recover_tag_i     = 4'(s.rtag);
      flush_i           = s.flush;
   endtask

   // One cycle: drive, predict, advance, compare against the scoreboard.
   task automatic cyc(stim_t s);
      exp_t e;
      drive(s);
      m_step(s);
      exp_q.push_back(m_out());
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk("sb_ready", int'(alloc_ready_o), int'(e.ready));
         chk("sb_count", int'(free_count_o), e.count);
         chk("sb_ovf", int'(overflow_o), int'(e.ovf));
         if (e.ready) chk("sb_preg", int'(alloc_preg_o), e.preg);
      end
   endtask

   task automatic hand(string nm, bit er, int ep, int ec, bit eo);
      chk({nm, "_ready"}, int'(alloc_ready_o), int'(er));
      if (er) chk({nm, "_preg"}, int'(alloc_preg_o), ep);
      chk({nm, "_count"}, int'(free_count_o), ec);
      chk({nm, "_ovf"}, int'(overflow_o), int'(eo));
   endtask

   stim_t idle;
   stim_t al;
   vec_t  tbl[$];

   initial begin
      idle = S(0, 0, 0, 0, 0, 0, 0, 0);
      al   = S(1, 0, 0, 0, 0, 0, 0, 0);
      tbl.push_back(V(al,                          1, 33, 95, 0));
      tbl.push_back(V(al,                          1, 34, 94, 0));
      tbl.push_back(V(al,                          1, 35, 93, 0));
      tbl.push_back(V(S(0, 1, 0, 0, 0, 0, 0, 0),   1, 35, 93, 0));
      tbl.push_back(V(S(1, 1, 50, 0, 0, 0, 0, 0),  1, 36, 93, 0));
      tbl.push_back(V(S(0, 1, 51, 0, 0, 0, 0, 0),  1, 36, 94, 0));
      tbl.push_back(V(S(0, 0, 0, 0, 0, 0, 0, 1),   1, 32, 96, 0));
      tbl.push_back(V(S(0, 1, 60, 0, 0, 0, 0, 0),  1, 32, 96, 1));
      tbl.push_back(V(al,                          1, 33, 95, 1));
      tbl.push_back(V(S(0, 0, 0, 0, 0, 0, 0, 1),   1, 32, 96, 0));
      tbl.push_back(V(S(1, 0, 0, 1, 3, 0, 0, 0),   1, 33, 95, 0));
      tbl.push_back(V(al,                          1, 34, 94, 0));
      tbl.push_back(V(al,                          1, 35, 93, 0));
      tbl.push_back(V(al,                          1, 36, 92, 0));
      tbl.push_back(V(al,                          1, 37, 91, 0));
      tbl.push_back(V(S(0, 1, 7, 0, 0, 0, 0, 0),   1, 37, 92, 0));
      tbl.push_back(V(S(0, 0, 0, 0, 0, 1, 3, 0),   1, 33, 96, 0));
      tbl.push_back(V(S(0, 0, 0, 0, 0, 1, 3, 0),   1, 33, 96, 0));
      tbl.push_back(V(S(1, 0, 0, 0, 0, 1, 3, 1),   1, 33, 96, 0));
      tbl.push_back(V(S(0, 0, 0, 1, 5, 0, 0, 1),   1, 32, 96, 0));
      tbl.push_back(V(S(0, 0, 0, 0, 0, 1, 5, 0),   1, 32, 96, 0));
      tbl.push_back(V(S(0, 1, 9, 0, 0, 0, 0, 1),   1, 32, 96, 0));

      m_init();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      hand("reset", 1, 32, 96, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].s);
         hand($sformatf("vec%0d", i), tbl[i].er, tbl[i].ep, tbl[i].ec, tbl[i].eo);
      end

      // Drain to empty, alloc while empty, then refill with one preg.
      repeat (FI) cyc(al);
      hand("drained", 0, 0, 0, 0);
      cyc(al);
      hand("empty_alloc", 0, 0, 0, 0);
      cyc(S(0, 1, 40, 0, 0, 0, 0, 0));
      hand("refill", 1, 40, 1, 0);

      // Same-cycle alloc and free at full count; freed preg comes out last.
      cyc(S(0, 0, 0, 0, 0, 0, 0, 1));
      cyc(S(1, 1, 5, 0, 0, 0, 0, 0));
      hand("alloc_free", 1, 33, 96, 0);
      repeat (FI - 1) cyc(al);
      hand("preg5_last", 1, 5, 1, 0);

      // Randomised traffic across pointer wrap with checkpoints and recovery.
      for (int i = 0; i < 600; i++) begin
         stim_t s;
         s = S($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, NP - 1),
               $urandom_range(0, 7) == 0, $urandom_range(0, RD - 1),
               $urandom_range(0, 19) == 0, $urandom_range(0, RD - 1),
               $urandom_range(0, 79) == 0);
         if (m_span() >= FI) s.free = 1'b0;
         cyc(s);
      end

      // Asynchronous reset in the middle of an alloc burst.
      repeat (3) cyc(al);
      drive(al);
      #3 rst = 1'b1;
      #1;
      hand("async_rst", 1, 32, 96, 0);
      m_init();
      drive(idle);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      hand("post_rst", 1, 32, 96, 0);
      cyc(S(0, 1, 0, 0, 0, 0, 0, 0));
      hand("free_zero", 1, 32, 96, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
